instr_builder: RTL



---
 rtl/alu_pkg.sv | 26 ++
 rtl/instr_builder_if.sv | 26 ++
 rtl/instr_builder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU-datapath definitions: operand/opcode widths, instruction field
// positions and the entry-stage encoding used by the builder, FIFO and display.
package alu_pkg;

   localparam int DW = 6;
   localparam int SW = 3;
   localparam int IW = 2 * DW + SW;

   localparam int A_HI = 14;
   localparam int A_LO = 9;
   localparam int B_HI = 8;
   localparam int B_LO = 3;
   localparam int S_HI = 2;
   localparam int S_LO = 0;

   localparam int OP_MAX_DEFAULT = 5;

   // Encoding doubles as the 2-bit stage output that drives the entry LEDs.
   typedef enum logic [1:0] {
      ENTER_A  = 2'd0,
      ENTER_B  = 2'd1,
      ENTER_OP = 2'd2,
      HOLD     = 2'd3
   } entry_state_t;

endpackage

// File: rtl/instr_builder_if.sv
// Bundle between the button/switch front end and the instruction builder,
// including the FIFO write side (instr/instr_valid, fifo_full).
interface instr_builder_if;
   import alu_pkg::*;

   logic          press;
   logic          cancel;
   logic [DW-1:0] sw;
   logic          fifo_full;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic [1:0]    stage;
   logic [IW-1:0] preview;
   logic          reject;

   modport master (
      output press, cancel, sw, fifo_full,
      input  instr, instr_valid, stage, preview, reject
   );

   modport slave (
      input  press, cancel, sw, fifo_full,
      output instr, instr_valid, stage, preview, reject
   );

endinterface

// File: rtl/instr_builder.sv
// Builds the 15-bit {A,B,select} instruction from one 6-bit switch bank over
// three presses, then strobes it into the instruction FIFO.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ENTER_A  | waiting for press to latch operand A from sw
//  ENTER_B  | waiting for press to latch operand B from sw
//  ENTER_OP | waiting for press with a legal opcode in sw[SW-1:0]
//  HOLD     | word assembled, waiting for fifo_full to drop
module instr_builder
   import alu_pkg::*;
#(
   parameter int OP_MAX = OP_MAX_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   instr_builder_if.slave bus
);

   localparam logic [SW-1:0] OP_LIMIT = SW'(OP_MAX);

   entry_state_t  state_q;
   entry_state_t  state_d;

   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [SW-1:0] sel_q;
   logic [IW-1:0] instr_q;
   logic          valid_q;
   logic          reject_q;

   logic [SW-1:0] op_sw;
   logic          op_legal;
   logic          load_a;
   logic          load_b;
   logic          load_op;
   logic          issue;
   logic          bad_op;
   logic          clear_fields;

   assign op_sw    = bus.sw[SW-1:0];
   assign op_legal = (op_sw <= OP_LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ENTER_A;
      end else begin
         state_q <= state_d;
      end
   end

   // cancel outranks press everywhere; in HOLD it also outranks the issue.
   always_comb begin
      state_d      = state_q;
      load_a       = 1'b0;
      load_b       = 1'b0;
      load_op      = 1'b0;
      issue        = 1'b0;
      bad_op       = 1'b0;
      clear_fields = 1'b0;
      case (state_q)
         ENTER_A: begin
            if (bus.cancel) begin
               clear_fields = 1'b1;
            end else if (bus.press) begin
               load_a  = 1'b1;
               state_d = ENTER_B;
            end
         end
         ENTER_B: begin
            if (bus.cancel) begin
               clear_fields = 1'b1;
               state_d      = ENTER_A;
            end else if (bus.press) begin
               load_b  = 1'b1;
               state_d = ENTER_OP;
            end
         end
         ENTER_OP: begin
            if (bus.cancel) begin
               clear_fields = 1'b1;
               state_d      = ENTER_A;
            end else if (bus.press) begin
               if (!op_legal) begin
                  bad_op = 1'b1;
               end else begin
                  load_op = 1'b1;
                  if (bus.fifo_full) begin
                     state_d = HOLD;
                  end else begin
                     issue   = 1'b1;
                     state_d = ENTER_A;
                  end
               end
            end
         end
         HOLD: begin
            if (bus.cancel) begin
               state_d = ENTER_A;
            end else if (!bus.fifo_full) begin
               issue   = 1'b1;
               state_d = ENTER_A;
            end
         end
         default: begin
            state_d = ENTER_A;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         sel_q    <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         valid_q  <= issue;
         reject_q <= bad_op;
         if (clear_fields) begin
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= '0;
         end
         if (load_a) begin
            a_q <= bus.sw;
         end
         if (load_b) begin
            b_q <= bus.sw;
         end
         if (load_op) begin
            sel_q   <= op_sw;
            instr_q <= {a_q, b_q, op_sw};
         end
      end
   end

   // Live word for the entry display: sw stands in for the slot being entered.
   always_comb begin
      bus.stage   = state_q;
      bus.preview = '0;
      case (state_q)
         ENTER_A: begin
            bus.preview[A_HI:A_LO] = bus.sw;
         end
         ENTER_B: begin
            bus.preview[A_HI:A_LO] = a_q;
            bus.preview[B_HI:B_LO] = bus.sw;
         end
         ENTER_OP: begin
            bus.preview[A_HI:A_LO] = a_q;
            bus.preview[B_HI:B_LO] = b_q;
            bus.preview[S_HI:S_LO] = op_sw;
         end
         HOLD: begin
            bus.preview = instr_q;
         end
         default: begin
            bus.preview = '0;
         end
      endcase
   end

   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.reject      = reject_q;

endmodule
